// File: rtl/issue_pkg.sv
// Shared types and helpers for the age-ordered issue queue.
// The entry layout is fixed by the IQ_* widths below.
package issue_pkg;

  localparam int IQ_N_ENTRIES     = 8;
  localparam int IQ_N_BCAST       = 2;
  localparam int IQ_DATA_WIDTH    = 32;
  localparam int IQ_ROB_ID_WIDTH  = 5;
  localparam int IQ_PAYLOAD_WIDTH = 64;
  localparam int IQ_MAX_ENTRIES   = 64;

  typedef struct packed {
    logic                       valid;
    logic                       ready;
    logic [IQ_ROB_ID_WIDTH-1:0] tag;
    logic [IQ_DATA_WIDTH-1:0]   data;
  } iq_src_t;

  typedef struct packed {
    iq_src_t                     src1;
    iq_src_t                     src2;
    logic [IQ_PAYLOAD_WIDTH-1:0] payload;
  } iq_entry_t;

  // An operand the uop does not use counts as present.
  function automatic logic src_ok(input iq_src_t s);
    return ~s.valid | s.ready;
  endfunction

  function automatic iq_src_t src_wake(input iq_src_t s, input logic hit,
                                       input logic [IQ_DATA_WIDTH-1:0] d);
    iq_src_t r;
    r = s;
    if (hit) begin
      r.ready = 1'b1;
      r.data  = d;
    end
    return r;
  endfunction

  // Find-first-one: index of the lowest set bit, 0 when none set.
  function automatic logic [5:0] iq_ff1(input logic [IQ_MAX_ENTRIES-1:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = IQ_MAX_ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/iq_src_capture.sv
// Compares one waiting operand tag against every broadcast channel.
// The lowest-numbered matching channel supplies the data.
module iq_src_capture #(
  parameter int N_BCAST    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                          waiting,
  input  logic [TAG_WIDTH-1:0]          tag,
  input  logic [N_BCAST-1:0]            bc_valid,
  input  logic [N_BCAST*TAG_WIDTH-1:0]  bc_tag,
  input  logic [N_BCAST*DATA_WIDTH-1:0] bc_data,
  output logic                          hit,
  output logic                          multi,
  output logic [DATA_WIDTH-1:0]         data
);

  logic [N_BCAST-1:0] match;

  for (genvar gi = 0; gi < N_BCAST; gi++) begin : g_match
    assign match[gi] = bc_valid[gi] && (bc_tag[gi*TAG_WIDTH +: TAG_WIDTH] == tag);
  end

  always_comb begin
    data = '0;
    for (int c = N_BCAST - 1; c >= 0; c--) begin
      if (match[c]) data = bc_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign hit   = waiting & (|match);
  assign multi = waiting && ($countones(match) > 1);

endmodule

// File: rtl/param_issue_queue.sv
// Age-ordered single-issue reservation station: compacting queue with broadcast
// wakeup, oldest-ready select and a registered ready/valid issue slot.
module param_issue_queue
  import issue_pkg::*;
#(
  parameter int N_ENTRIES     = IQ_N_ENTRIES,
  parameter int N_BCAST       = IQ_N_BCAST,
  parameter int DATA_WIDTH    = IQ_DATA_WIDTH,
  parameter int ROB_ID_WIDTH  = IQ_ROB_ID_WIDTH,
  parameter int PAYLOAD_WIDTH = IQ_PAYLOAD_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_aH,
  input  logic                             flush,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  iq_entry_t                        disp_entry,
  input  logic [N_BCAST-1:0]               bc_valid,
  input  logic [N_BCAST*ROB_ID_WIDTH-1:0]  bc_tag,
  input  logic [N_BCAST*DATA_WIDTH-1:0]    bc_data,
  output logic                             iss_valid,
  input  logic                             iss_ready,
  output logic [DATA_WIDTH-1:0]            iss_src1_data,
  output logic [DATA_WIDTH-1:0]            iss_src2_data,
  output logic [PAYLOAD_WIDTH-1:0]         iss_payload,
  output logic [$clog2(N_ENTRIES+1)-1:0]   occupancy
);

  localparam int CNT_W = $clog2(N_ENTRIES + 1);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int MV_W  = 2 * N_ENTRIES + 4;

  iq_entry_t entry_reg  [N_ENTRIES];
  iq_entry_t entry_next [N_ENTRIES];
  iq_entry_t woken      [N_ENTRIES];
  logic [CNT_W-1:0] count_reg, count_next, wr_ptr;
  logic [IDX_W-1:0] wr_idx, sel_idx;
  logic [N_ENTRIES-1:0] valid, eligible;
  logic [MV_W-1:0] multi_vec;

  logic iss_valid_reg;
  logic [DATA_WIDTH-1:0] iss_src1_reg, iss_src2_reg;
  logic [PAYLOAD_WIDTH-1:0] iss_payload_reg;

  logic slot_free, any_elig, deq, enq;

  // Per-entry wakeup from the broadcast channels.
  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
    logic h1, h2;
    logic [DATA_WIDTH-1:0] d1, d2;

    assign valid[gi] = CNT_W'(gi) < count_reg;

    iq_src_capture #(.N_BCAST(N_BCAST), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(ROB_ID_WIDTH)) u_cap1 (
      .waiting (valid[gi] & entry_reg[gi].src1.valid & ~entry_reg[gi].src1.ready),
      .tag     (entry_reg[gi].src1.tag),
      .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
      .hit(h1), .multi(multi_vec[2*gi]), .data(d1)
    );
    iq_src_capture #(.N_BCAST(N_BCAST), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(ROB_ID_WIDTH)) u_cap2 (
      .waiting (valid[gi] & entry_reg[gi].src2.valid & ~entry_reg[gi].src2.ready),
      .tag     (entry_reg[gi].src2.tag),
      .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
      .hit(h2), .multi(multi_vec[2*gi+1]), .data(d2)
    );

    assign woken[gi] = '{src1:    src_wake(entry_reg[gi].src1, h1, d1),
                         src2:    src_wake(entry_reg[gi].src2, h2, d2),
                         payload: entry_reg[gi].payload};

    // Eligibility uses only registered state; a wakeup counts from the next cycle.
    assign eligible[gi] = valid[gi] & src_ok(entry_reg[gi].src1) & src_ok(entry_reg[gi].src2);
  end

  // Incoming uop sees same-cycle broadcasts so no wakeup slips past it.
  logic dh1, dh2;
  logic [DATA_WIDTH-1:0] dd1, dd2;
  iq_entry_t disp_woken;

  iq_src_capture #(.N_BCAST(N_BCAST), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(ROB_ID_WIDTH)) u_disp_cap1 (
    .waiting (disp_valid & disp_entry.src1.valid & ~disp_entry.src1.ready),
    .tag     (disp_entry.src1.tag),
    .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
    .hit(dh1), .multi(multi_vec[2*N_ENTRIES]), .data(dd1)
  );
  iq_src_capture #(.N_BCAST(N_BCAST), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(ROB_ID_WIDTH)) u_disp_cap2 (
    .waiting (disp_valid & disp_entry.src2.valid & ~disp_entry.src2.ready),
    .tag     (disp_entry.src2.tag),
    .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
    .hit(dh2), .multi(multi_vec[2*N_ENTRIES+1]), .data(dd2)
  );

  assign disp_woken = '{src1:    src_wake(disp_entry.src1, dh1, dd1),
                        src2:    src_wake(disp_entry.src2, dh2, dd2),
                        payload: disp_entry.payload};

  // Oldest-ready select with same-cycle broadcast bypass into the slot.
  iq_entry_t sel_entry;
  iq_src_t sel_src1, sel_src2;
  logic sh1, sh2;
  logic [DATA_WIDTH-1:0] sd1, sd2;

  assign sel_idx   = IDX_W'(iq_ff1(IQ_MAX_ENTRIES'(eligible)));
  assign any_elig  = |eligible;
  assign sel_entry = entry_reg[sel_idx];
  assign slot_free = ~iss_valid_reg | iss_ready;
  assign deq       = slot_free & any_elig & ~flush;

  iq_src_capture #(.N_BCAST(N_BCAST), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(ROB_ID_WIDTH)) u_sel_cap1 (
    .waiting (any_elig & sel_entry.src1.valid & ~sel_entry.src1.ready),
    .tag     (sel_entry.src1.tag),
    .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
    .hit(sh1), .multi(multi_vec[2*N_ENTRIES+2]), .data(sd1)
  );
  iq_src_capture #(.N_BCAST(N_BCAST), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(ROB_ID_WIDTH)) u_sel_cap2 (
    .waiting (any_elig & sel_entry.src2.valid & ~sel_entry.src2.ready),
    .tag     (sel_entry.src2.tag),
    .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
    .hit(sh2), .multi(multi_vec[2*N_ENTRIES+3]), .data(sd2)
  );

  assign sel_src1 = src_wake(sel_entry.src1, sh1, sd1);
  assign sel_src2 = src_wake(sel_entry.src2, sh2, sd2);

  // Full-queue backpressure ignores the same-cycle dequeue to keep it off the comb path.
  assign disp_ready = count_reg < CNT_W'(N_ENTRIES);
  assign enq        = disp_valid & disp_ready & ~flush;
  assign wr_ptr     = count_reg - CNT_W'(deq);
  assign wr_idx     = IDX_W'(wr_ptr);
  assign count_next = count_reg + CNT_W'(enq) - CNT_W'(deq);

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      entry_next[i] = woken[i];
      if (deq && (i < N_ENTRIES - 1) && (IDX_W'(i) >= sel_idx))
        entry_next[i] = woken[(i < N_ENTRIES - 1) ? i + 1 : i];
    end
    if (enq) entry_next[wr_idx] = disp_woken;
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      count_reg <= '0;
      for (int i = 0; i < N_ENTRIES; i++) entry_reg[i] <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < N_ENTRIES; i++) entry_reg[i] <= entry_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      iss_valid_reg   <= 1'b0;
      iss_src1_reg    <= '0;
      iss_src2_reg    <= '0;
      iss_payload_reg <= '0;
    end else if (flush) begin
      iss_valid_reg <= 1'b0;
    end else if (slot_free) begin
      iss_valid_reg <= deq;
      if (deq) begin
        iss_src1_reg    <= sel_src1.data;
        iss_src2_reg    <= sel_src2.data;
        iss_payload_reg <= sel_entry.payload;
      end
    end
  end

  assign iss_valid     = iss_valid_reg;
  assign iss_src1_data = iss_src1_reg;
  assign iss_src2_data = iss_src2_reg;
  assign iss_payload   = iss_payload_reg;
  assign occupancy     = count_reg;

  // Two channels carrying a tag some waiting operand wants is an upstream bug.
  no_multi_match: assert property (@(posedge clk) disable iff (rst_aH) !(|multi_vec));

endmodule

// File: tb/tb_param_issue_queue.sv
// Self-checking bench for param_issue_queue: vector table for single-uop
// wakeup/latency cases, hand sequences for fill, age order, flush and reset.
module tb_param_issue_queue;
  import issue_pkg::*;

  logic clk = 1'b0;
  logic rst_aH, flush, disp_valid, disp_ready, iss_valid, iss_ready;
  iq_entry_t disp_entry;
  logic [1:0] bc_valid;
  logic [9:0] bc_tag;
  logic [63:0] bc_data;
  logic [31:0] iss_src1_data, iss_src2_data;
  logic [63:0] iss_payload;
  logic [3:0] occupancy;

  param_issue_queue dut (
    .clk(clk), .rst_aH(rst_aH), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_entry(disp_entry),
    .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1_data(iss_src1_data), .iss_src2_data(iss_src2_data),
    .iss_payload(iss_payload), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [63:0] pay;
  } exp_t;

  typedef struct {
    iq_entry_t   ent;
    logic [1:0]  bcv;
    logic [4:0]  bct0;
    logic [4:0]  bct1;
    logic [31:0] bcd0;
    logic [31:0] bcd1;
    int          bc_delay;  // -1: none, 0: with dispatch, k: k cycles after dispatch edge
    logic [31:0] exp1;
    logic [31:0] exp2;
    int          exp_lat;   // edges after the dispatch edge until iss_valid
  } vec_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic iq_entry_t mk(input logic v1, input logic r1, input logic [4:0] t1,
                                   input logic [31:0] d1, input logic v2, input logic r2,
                                   input logic [4:0] t2, input logic [31:0] d2,
                                   input logic [63:0] pay);
    iq_entry_t e;
    e.src1    = '{valid: v1, ready: r1, tag: t1, data: d1};
    e.src2    = '{valid: v2, ready: r2, tag: t2, data: d2};
    e.payload = pay;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bc(input logic [1:0] v, input logic [4:0] t0, input logic [4:0] t1,
                        input logic [31:0] d0, input logic [31:0] d1);
    bc_valid = v;
    bc_tag   = {t1, t0};
    bc_data  = {d1, d0};
  endtask

  // One-cycle dispatch; optionally record the expected issue data.
  task automatic dispatch(input iq_entry_t e, input logic push);
    exp_t x;
    disp_valid = 1'b1;
    disp_entry = e;
    if (push) begin
      x.d1 = e.src1.data; x.d2 = e.src2.data; x.pay = e.payload;
      exp_q.push_back(x);
    end
    tick();
    disp_valid = 1'b0;
  endtask

  // Scoreboard: every accepted issue must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_aH && !flush && iss_valid && iss_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_issue: got payload %0h required no issue", iss_payload);
        end else begin
          e = exp_q.pop_front();
          chk("iss_src1_data", 64'(iss_src1_data), 64'(e.d1));
          chk("iss_src2_data", 64'(iss_src2_data), 64'(e.d2));
          chk("iss_payload", iss_payload, e.pay);
          $display("issue payload=%0h src1=%0h src2=%0h", iss_payload, iss_src1_data, iss_src2_data);
        end
      end
    end
  end

  vec_t vecs[8];

  initial begin
    int lat;
    int guard;
    exp_t x;
    iq_entry_t e;

    vecs[0] = '{ent: mk(1'b0, 1'b0, 5'd0, 32'h11, 1'b0, 1'b0, 5'd0, 32'h22, 64'hA0),
                bcv: 2'b00, bct0: 5'd0, bct1: 5'd0, bcd0: 32'h0, bcd1: 32'h0, bc_delay: -1,
                exp1: 32'h11, exp2: 32'h22, exp_lat: 1};
    vecs[1] = '{ent: mk(1'b1, 1'b1, 5'd1, 32'h1234, 1'b1, 1'b1, 5'd2, 32'h5678, 64'hA1),
                bcv: 2'b00, bct0: 5'd0, bct1: 5'd0, bcd0: 32'h0, bcd1: 32'h0, bc_delay: -1,
                exp1: 32'h1234, exp2: 32'h5678, exp_lat: 1};
    vecs[2] = '{ent: mk(1'b1, 1'b0, 5'd5, 32'h0, 1'b1, 1'b1, 5'd2, 32'h22, 64'hA2),
                bcv: 2'b10, bct0: 5'd0, bct1: 5'd5, bcd0: 32'h0, bcd1: 32'hDEAD, bc_delay: 2,
                exp1: 32'hDEAD, exp2: 32'h22, exp_lat: 3};
    vecs[3] = '{ent: mk(1'b1, 1'b0, 5'd7, 32'h0, 1'b0, 1'b0, 5'd0, 32'h33, 64'hA3),
                bcv: 2'b01, bct0: 5'd7, bct1: 5'd0, bcd0: 32'hBEEF, bcd1: 32'h0, bc_delay: 0,
                exp1: 32'hBEEF, exp2: 32'h33, exp_lat: 1};
    vecs[4] = '{ent: mk(1'b1, 1'b1, 5'd1, 32'h44, 1'b1, 1'b0, 5'd9, 32'h0, 64'hA4),
                bcv: 2'b01, bct0: 5'd9, bct1: 5'd0, bcd0: 32'h9999, bcd1: 32'h0, bc_delay: 1,
                exp1: 32'h44, exp2: 32'h9999, exp_lat: 2};
    vecs[5] = '{ent: mk(1'b1, 1'b0, 5'd3, 32'h0, 1'b1, 1'b0, 5'd4, 32'h0, 64'hA5),
                bcv: 2'b11, bct0: 5'd3, bct1: 5'd4, bcd0: 32'hC0C0, bcd1: 32'hD0D0, bc_delay: 2,
                exp1: 32'hC0C0, exp2: 32'hD0D0, exp_lat: 3};
    vecs[6] = '{ent: mk(1'b1, 1'b0, 5'd12, 32'h0, 1'b1, 1'b0, 5'd31, 32'h0, 64'hA6),
                bcv: 2'b11, bct0: 5'd31, bct1: 5'd12, bcd0: 32'h3131, bcd1: 32'h1212, bc_delay: 3,
                exp1: 32'h1212, exp2: 32'h3131, exp_lat: 4};
    // Unused or already-ready operands must ignore a matching broadcast.
    vecs[7] = '{ent: mk(1'b0, 1'b0, 5'd3, 32'h1111, 1'b1, 1'b1, 5'd4, 32'h2222, 64'hA7),
                bcv: 2'b11, bct0: 5'd3, bct1: 5'd4, bcd0: 32'h9999, bcd1: 32'h8888, bc_delay: 0,
                exp1: 32'h1111, exp2: 32'h2222, exp_lat: 1};

    rst_aH = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_entry = '0; iss_ready = 1'b0;
    set_bc(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #12;
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_iss_valid", 64'(iss_valid), 64'd0);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    chk("reset_iss_payload", iss_payload, 64'd0);
    chk("reset_iss_src1", 64'(iss_src1_data), 64'd0);
    tick();
    rst_aH = 1'b0;
    tick();

    // Table: single uop on an empty queue with the FU always ready.
    iss_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x.d1 = vecs[i].exp1; x.d2 = vecs[i].exp2; x.pay = vecs[i].ent.payload;
      exp_q.push_back(x);
      if (vecs[i].bc_delay == 0)
        set_bc(vecs[i].bcv, vecs[i].bct0, vecs[i].bct1, vecs[i].bcd0, vecs[i].bcd1);
      dispatch(vecs[i].ent, 1'b0);
      chk($sformatf("v%0d_occ_after_disp", i), 64'(occupancy), 64'd1);
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        if (k == vecs[i].bc_delay)
          set_bc(vecs[i].bcv, vecs[i].bct0, vecs[i].bct1, vecs[i].bcd0, vecs[i].bcd1);
        else
          set_bc(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();
        if (iss_valid) begin
          lat = k;
          break;
        end
      end
      set_bc(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_occ_after_sel", i), 64'(occupancy), 64'd0);
      tick();
      chk($sformatf("v%0d_slot_drained", i), 64'(iss_valid), 64'd0);
    end

    // bc_valid low never wakes, even with a matching tag.
    set_bc(2'b00, 5'd6, 5'd6, 32'hBAD0, 32'hBAD1);
    dispatch(mk(1'b1, 1'b0, 5'd6, 32'h0, 1'b0, 1'b0, 5'd0, 32'h66, 64'hB0), 1'b0);
    tick(); tick();
    chk("bcinv_occupancy", 64'(occupancy), 64'd1);
    chk("bcinv_no_issue", 64'(iss_valid), 64'd0);
    x.d1 = 32'h6666; x.d2 = 32'h66; x.pay = 64'hB0;
    exp_q.push_back(x);
    set_bc(2'b10, 5'd0, 5'd6, 32'h0, 32'h6666);
    tick();
    set_bc(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("bcinv_issued", 64'(iss_valid), 64'd1);
    tick();

    // Fill with FU stalled: first uop parks in the slot, 8 more fill the queue.
    iss_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      dispatch(mk(1'b1, 1'b1, 5'd1, 32'h100 + 32'(k), 1'b0, 1'b0, 5'd0, 32'h200 + 32'(k),
                  64'hC00 + 64'(k)), 1'b1);
      if (k == 1) begin
        chk("enq_deq_occupancy", 64'(occupancy), 64'd1);
        chk("enq_deq_iss_valid", 64'(iss_valid), 64'd1);
      end
    end
    chk("full_occupancy", 64'(occupancy), 64'd8);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    disp_valid = 1'b1;
    disp_entry = mk(1'b0, 1'b0, 5'd0, 32'hBAD, 1'b0, 1'b0, 5'd0, 32'hBAD, 64'hBAD);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_iss_valid", 64'(iss_valid), 64'd1);
      chk("stall_payload", iss_payload, 64'hC00);
      chk("stall_occupancy", 64'(occupancy), 64'd8);
    end
    iss_ready = 1'b1;
    tick();
    disp_valid = 1'b0;
    chk("full_deq_no_enq_occ", 64'(occupancy), 64'd7);
    guard = 0;
    while ((iss_valid || occupancy != 4'd0) && guard < 20) begin
      tick();
      guard++;
    end
    chk("fill_drain_done", 64'(guard < 20), 64'd1);
    chk("fill_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Age order: older uop waits, younger ready ones pass it.
    iss_ready = 1'b0;
    dispatch(mk(1'b1, 1'b0, 5'd10, 32'h0, 1'b1, 1'b1, 5'd2, 32'hD2, 64'hD0), 1'b0);
    dispatch(mk(1'b1, 1'b1, 5'd1, 32'hD11, 1'b0, 1'b0, 5'd0, 32'hD12, 64'hD1), 1'b1);
    dispatch(mk(1'b0, 1'b0, 5'd1, 32'hD21, 1'b1, 1'b1, 5'd3, 32'hD22, 64'hD2), 1'b1);
    iss_ready = 1'b1;
    tick(); tick(); tick();
    chk("age_waiting_left", 64'(occupancy), 64'd1);
    chk("age_slot_empty", 64'(iss_valid), 64'd0);
    x.d1 = 32'hA0A0; x.d2 = 32'hD2; x.pay = 64'hD0;
    exp_q.push_back(x);
    set_bc(2'b10, 5'd0, 5'd10, 32'h0, 32'hA0A0);
    tick();
    set_bc(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    guard = 0;
    while (!iss_valid && guard < 5) begin
      tick();
      guard++;
    end
    chk("age_woken_issued", 64'(iss_valid), 64'd1);
    chk("age_occ_zero", 64'(occupancy), 64'd0);
    tick();

    // Flush with a dispatch in the same cycle.
    iss_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      dispatch(mk(1'b0, 1'b0, 5'd0, 32'hE0, 1'b0, 1'b0, 5'd0, 32'hE1, 64'hE00 + 64'(k)), 1'b1);
    chk("preflush_occupancy", 64'(occupancy), 64'd4);
    chk("preflush_iss_valid", 64'(iss_valid), 64'd1);
    flush = 1'b1;
    disp_valid = 1'b1;
    disp_entry = mk(1'b0, 1'b0, 5'd0, 32'hF0, 1'b0, 1'b0, 5'd0, 32'hF1, 64'hF00);
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    exp_q.delete();
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    chk("flush_iss_valid", 64'(iss_valid), 64'd0);
    iss_ready = 1'b1;
    tick(); tick(); tick();
    chk("flush_dropped_disp", 64'(occupancy), 64'd0);
    chk("flush_no_issue", 64'(iss_valid), 64'd0);

    // Asynchronous reset between edges.
    iss_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      dispatch(mk(1'b0, 1'b0, 5'd0, 32'h70, 1'b0, 1'b0, 5'd0, 32'h71, 64'h700 + 64'(k)), 1'b1);
    chk("prereset_occupancy", 64'(occupancy), 64'd3);
    #2;
    rst_aH = 1'b1;
    #1;
    exp_q.delete();
    chk("async_rst_occupancy", 64'(occupancy), 64'd0);
    chk("async_rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("async_rst_disp_ready", 64'(disp_ready), 64'd1);
    tick();
    rst_aH = 1'b0;
    tick();
    chk("post_reset_occupancy", 64'(occupancy), 64'd0);
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
